// File: rtl/multicycle_ctrl.sv
// Five-state control FSM and instruction decoder for the multicycle RV32I core.
// Define MULTICYCLE_MEM_WAIT_EN to add dReady and let MEM stall for LW/SW.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic        dReady,
`endif
  output logic [2:0]  fsm_state,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        illegal_instr
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_e state_q, state_d;
  logic   br_q, br_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic       unused_instr;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign alt = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  logic       dec_src, dec_m2r, dec_wb, dec_ill;
  logic       is_lw, is_sw, is_beq;
  logic [3:0] dec_alu;
  logic       arith, arith_ill, rtype;
  logic [3:0] arith_alu;

  // Shared R/I arithmetic decode; funct7[5] only matters for R-type and SRAI.
  always_comb begin
    rtype     = (opc == OP_R);
    arith_ill = 1'b0;
    arith_alu = ALU_ADD;
    unique case (f3)
      3'b000: arith_alu = (rtype && alt) ? ALU_SUB : ALU_ADD;
      3'b001: arith_alu = ALU_SLL;
      3'b010: arith_alu = ALU_SLT;
      3'b011: arith_ill = 1'b1;
      3'b100: arith_alu = ALU_XOR;
      3'b101: arith_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110: arith_alu = ALU_OR;
      3'b111: arith_alu = ALU_AND;
      default: arith_ill = 1'b1;
    endcase
    if (rtype && alt && f3 != 3'b000 && f3 != 3'b101)
      arith_ill = 1'b1;
  end

  always_comb begin
    dec_src = 1'b0;
    dec_m2r = 1'b0;
    dec_wb  = 1'b0;
    dec_ill = 1'b0;
    dec_alu = ALU_ADD;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    arith   = (opc == OP_R) || (opc == OP_I);
    unique case (1'b1)
      arith: begin
        if (arith_ill) begin
          dec_ill = 1'b1;
        end else begin
          dec_src = (opc == OP_I);
          dec_alu = arith_alu;
          dec_wb  = 1'b1;
        end
      end
      opc == OP_LW: begin
        dec_src = 1'b1;
        dec_m2r = 1'b1;
        dec_wb  = 1'b1;
        is_lw   = 1'b1;
      end
      opc == OP_SW: begin
        dec_src = 1'b1;
        is_sw   = 1'b1;
      end
      opc == OP_BR && f3 == 3'b000: begin
        dec_alu = ALU_SUB;
        is_beq  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = S_IF;
    br_d          = br_q;
    ALUSrc        = 1'b0;
    ALUCtrl       = ALU_ADD;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemToReg      = 1'b0;
    RegWrite      = 1'b0;
    loadPC        = 1'b0;
    PCSrc         = 1'b0;
    illegal_instr = 1'b0;
    if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
      ALUSrc   = dec_src;
      ALUCtrl  = dec_alu;
      MemToReg = dec_m2r;
    end
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: state_d = S_EX;
      S_EX: begin
        state_d = S_MEM;
        br_d    = is_beq & Zero;
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        state_d  = S_WB;
`ifdef MULTICYCLE_MEM_WAIT_EN
        if ((is_lw || is_sw) && !dReady)
          state_d = S_MEM;
`endif
      end
      S_WB: begin
        RegWrite      = dec_wb;
        loadPC        = 1'b1;
        PCSrc         = br_q;
        illegal_instr = dec_ill;
        br_d          = 1'b0;
      end
      default: br_d = 1'b0;
    endcase
    // Reset kills every strobe at once so an aborted instruction has no effect.
    if (rst) begin
      ALUSrc        = 1'b0;
      ALUCtrl       = 4'b0000;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemToReg      = 1'b0;
      RegWrite      = 1'b0;
      loadPC        = 1'b0;
      PCSrc         = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven, scoreboarded bench for multicycle_ctrl.
// Wait-state sequences are added when MULTICYCLE_MEM_WAIT_EN is defined.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic        dReady;
`endif
  logic [2:0]  fsm_state;
  logic        ALUSrc;
  logic [3:0]  ALUCtrl;
  logic        MemRead, MemWrite, MemToReg, RegWrite;
  logic        loadPC, PCSrc, illegal_instr;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .Zero          (Zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .dReady        (dReady),
`endif
    .fsm_state     (fsm_state),
    .ALUSrc        (ALUSrc),
    .ALUCtrl       (ALUCtrl),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemToReg      (MemToReg),
    .RegWrite      (RegWrite),
    .loadPC        (loadPC),
    .PCSrc         (PCSrc),
    .illegal_instr (illegal_instr)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        src;
    logic [3:0]  alu;
    logic        m2r;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        pcs;
    logic        ill;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];
  logic [14:0] q[$];
  int errors = 0;
  int checks = 0;
  int tag = 0;

  // {state, ALUSrc, ALUCtrl, MemRead, MemWrite, MemToReg, RegWrite, loadPC, PCSrc, illegal}
  function automatic logic [14:0] expv(vec_t v, int s);
    logic [14:0] e;
    e = '0;
    e[14:12] = 3'(s);
    if (s == 0) begin
      e[10:7] = 4'b0010;
    end else begin
      e[11]   = v.src;
      e[10:7] = v.alu;
      e[4]    = v.m2r;
    end
    if (s == 3) begin
      e[6] = v.rd;
      e[5] = v.wr;
    end
    if (s == 4) begin
      e[3] = v.rw;
      e[2] = 1'b1;
      e[1] = v.pcs;
      e[0] = v.ill;
    end
    return e;
  endfunction

  task automatic step(input logic [14:0] e);
    logic [14:0] got, want;
    q.push_back(e);
    #2;
    got = {fsm_state, ALUSrc, ALUCtrl, MemRead, MemWrite,
           MemToReg, RegWrite, loadPC, PCSrc, illegal_instr};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL t%0d scoreboard empty got=%h", tag, got);
    end else begin
      want = q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL t%0d st=%0d got=%b want=%b",
                 tag, want[14:12], got, want);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int first, input int last);
    instr = v.instr;
    Zero  = v.zero;
    for (int s = first; s <= last; s++)
      step(expv(v, s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{32'h002081B3, 0, 0, 4'b0010, 0, 0, 0, 1, 0, 0};
    vt[1]  = '{32'h402081B3, 0, 0, 4'b0110, 0, 0, 0, 1, 0, 0};
    vt[2]  = '{32'h4020D193, 0, 1, 4'b1010, 0, 0, 0, 1, 0, 0};
    vt[3]  = '{32'h0000A183, 0, 1, 4'b0010, 1, 1, 0, 1, 0, 0};
    vt[4]  = '{32'h0030A023, 1, 1, 4'b0010, 0, 0, 1, 0, 0, 0};
    vt[5]  = '{32'h00208463, 1, 0, 4'b0110, 0, 0, 0, 0, 1, 0};
    vt[6]  = '{32'h00208463, 0, 0, 4'b0110, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{32'h0000007F, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 1};
    vt[8]  = '{32'h0020E1B3, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 0};
    vt[9]  = '{32'h0020F1B3, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0};
    vt[10] = '{32'h0020C1B3, 0, 0, 4'b0101, 0, 0, 0, 1, 0, 0};
    vt[11] = '{32'h0020A1B3, 0, 0, 4'b0111, 0, 0, 0, 1, 0, 0};
    vt[12] = '{32'h002091B3, 0, 0, 4'b1001, 0, 0, 0, 1, 0, 0};
    vt[13] = '{32'h0020D1B3, 0, 0, 4'b1000, 0, 0, 0, 1, 0, 0};
    vt[14] = '{32'h4020D1B3, 0, 0, 4'b1010, 0, 0, 0, 1, 0, 0};
    vt[15] = '{32'h40008193, 0, 1, 4'b0010, 0, 0, 0, 1, 0, 0};
    vt[16] = '{32'h00209463, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 1};
    vt[17] = '{32'h00208033, 0, 0, 4'b0010, 0, 0, 0, 1, 0, 0};

    rst   = 1'b1;
    instr = 32'h0;
    Zero  = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    dReady = 1'b1;
`endif
    @(negedge clk);
    tag = 100;
    step(15'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      tag = i;
      run_vec(vt[i], 0, 4);
    end

    // Reset while an LW sits in MEM: strobes drop now, IF next edge.
    tag = 101;
    run_vec(vt[3], 0, 2);
    rst = 1'b1;
    step({3'd3, 12'h0});
    step(15'h0);
    rst = 1'b0;
    tag = 102;
    run_vec(vt[0], 0, 4);

`ifdef MULTICYCLE_MEM_WAIT_EN
    // LW stalls in MEM three cycles, released on the fourth.
    tag = 103;
    dReady = 1'b0;
    run_vec(vt[3], 0, 3);
    step(expv(vt[3], 3));
    step(expv(vt[3], 3));
    dReady = 1'b1;
    step(expv(vt[3], 3));
    step(expv(vt[3], 4));

    // Non-memory op passes straight through MEM.
    tag = 104;
    dReady = 1'b0;
    run_vec(vt[0], 0, 4);

    // SW stall then reset during the wait.
    tag = 105;
    run_vec(vt[4], 0, 3);
    step(expv(vt[4], 3));
    rst = 1'b1;
    step({3'd3, 12'h0});
    step(15'h0);
    rst = 1'b0;
    dReady = 1'b1;
    tag = 106;
    run_vec(vt[5], 0, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
